checksum_unit: RTL

CHECKSUM_UNIT -- requirements
Module: checksum_unit

---
 rtl/checksum_unit_if.sv | 26 ++
 rtl/checksum_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/checksum_unit_if.sv
// RAM-side and request/result signals of checksum_unit.
// slave = the checksum engine, master = requester plus RAM model.
interface checksum_unit_if;
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned DATA_W = 8;

    logic              start;
    logic [ADR_W-1:0]  len;
    logic [ADR_W-1:0]  ram_adr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] checksum;
    logic              busy;
    logic              done;

    modport slave (
        input  start, len, ram_rdata,
        output ram_adr, ram_we, ram_wdata, checksum, busy, done
    );

    modport master (
        output start, len, ram_rdata,
        input  ram_adr, ram_we, ram_wdata, checksum, busy, done
    );
endinterface

// File: rtl/checksum_unit.sv
// One's-complement checksum over RAM bytes 0..len-1 read from a 16x8 synchronous RAM.
// Define CHECKSUM_WRITEBACK_EN to store the result at RAM[len] after the data.
module checksum_unit (
    input  logic            clk,
    input  logic            reset,
    checksum_unit_if.slave  bus
);
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
`ifdef CHECKSUM_WRITEBACK_EN
        WRITE = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADR_W-1:0]   len_q, len_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0]  cs_q, cs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  sum_add;
`ifdef CHECKSUM_WRITEBACK_EN
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
`endif

    // 8-bit add with end-around carry
    function automatic logic [DATA_W-1:0] oc_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
        return s[DATA_W-1:0] + DATA_W'(s[DATA_W]);
    endfunction

    assign sum_add = oc_add(sum_q, bus.ram_rdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            adr_q   <= '0;
            sum_q   <= '0;
            cs_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CHECKSUM_WRITEBACK_EN
            we_q    <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            adr_q   <= adr_d;
            sum_q   <= sum_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CHECKSUM_WRITEBACK_EN
            we_q    <= we_d;
            wdata_q <= wdata_d;
`endif
        end
    end

    // Next state and next registered outputs; read data lags the address by one cycle
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        adr_d   = adr_q;
        sum_d   = sum_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef CHECKSUM_WRITEBACK_EN
        we_d    = 1'b0;
        wdata_d = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d = bus.len;
                    sum_d = '0;
                    adr_d = '0;
                    if (bus.len == ADR_W'(0)) begin
                        cs_d    = 8'hFF;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // First RUN cycle has no valid read data yet
                if (adr_q != ADR_W'(0)) begin
                    sum_d = sum_add;
                end
                if (adr_q == ADR_W'(len_q - ADR_W'(1))) begin
                    state_d = FLUSH;
                end else begin
                    adr_d = ADR_W'(adr_q + ADR_W'(1));
                end
            end
            FLUSH: begin
                sum_d = sum_add;
                cs_d  = ~sum_add;
`ifdef CHECKSUM_WRITEBACK_EN
                adr_d   = len_q;
                we_d    = 1'b1;
                wdata_d = ~sum_add;
                state_d = WRITE;
`else
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
`endif
            end
`ifdef CHECKSUM_WRITEBACK_EN
            WRITE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ram_adr  = adr_q;
    assign bus.checksum = cs_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef CHECKSUM_WRITEBACK_EN
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
`else
    assign bus.ram_we    = 1'b0;
    assign bus.ram_wdata = 8'h00;
`endif
endmodule
